counter_ud_mod: RTL
===================

COUNTER_UD_MOD -- requirements
Module: counter_ud_mod

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX, default 2**WIDTH-1: upper count bound, legal range 1..2**WIDTH-1; the count range is 0..MAX.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous and active-high.
REQ-005 Port en, input, 1: count enable.
REQ-006 Port ud, input, 1: direction; 1 = up, 0 = down.
REQ-007 Port load, input, 1: synchronous load strobe.
REQ-008 Port load_val, input, WIDTH: value to load.
REQ-009 Port mode, input, 1: bound behaviour; 0 = WRAP, 1 = SATURATE.
REQ-010 Port clr_flag, input, 1: clears sat_flag.
REQ-011 Port out, output, WIDTH: current count, registered.
REQ-012 Port tc, output, 1: terminal count, combinational from out and ud.
REQ-013 Port wrap_evt, output, 1: one-cycle registered pulse marking a wrap.
REQ-014 Port sat_flag, output, 1: sticky saturation-attempt flag, registered.

Function
REQ-015 Priority per edge SHALL be reset > load > en; with en=0 and load=0, out SHALL hold.
REQ-016 On load, out SHALL take load_val if load_val <= MAX, else MAX; wrap_evt SHALL be 0 that cycle; sat_flag is unaffected.
REQ-017 With en=1 and ud=1, out SHALL go to out+1 when out < MAX.
REQ-018 With en=1 and ud=0, out SHALL go to out-1 when out > 0.
REQ-019 In WRAP mode, up-count at out=MAX SHALL give out=0, and down-count at out=0 SHALL give out=MAX; wrap_evt SHALL be 1 in the cycle following that edge only.
REQ-020 In SATURATE mode, up-count at MAX and down-count at 0 SHALL hold out; sat_flag SHALL be set on that edge; wrap_evt SHALL stay 0.
REQ-021 tc SHALL be 1 when (ud=1 and out=MAX) or (ud=0 and out=0), regardless of en and mode.
REQ-022 sat_flag SHALL be cleared by clr_flag=1; if a set and a clear occur on the same edge, set SHALL win.
REQ-023 Changes to ud or mode SHALL take effect on the next edge with no extra latency; a direction reversal SHALL not skip or repeat a count.
REQ-024 Counter arithmetic SHALL be WIDTH bits with no intermediate overflow at MAX=2**WIDTH-1.

Reset
REQ-025 On a reset edge: out=0, wrap_evt=0, sat_flag=0; tc then follows REQ-021 (1 if ud=0).
REQ-026 Reset asserted mid-count SHALL override load and en on that edge; counting SHALL resume from 0 on the first edge after reset deasserts.

Structure
REQ-027 Package counter_pkg SHALL hold the mode encodings MODE_WRAP=1'b0 and MODE_SAT=1'b1.
REQ-028 Sub-module counter_next (combinational) SHALL compute the next count, the wrap indication and the saturation attempt from out, ud, mode and MAX; counter_ud_mod SHALL hold all registers.
REQ-029 Parameter legality SHALL be checked at elaboration: MAX must be > 0 and must fit in WIDTH bits.

Verification (WIDTH=8 unless stated)
REQ-030 Wrap up: MAX=9, mode=0, ud=1, en=1 for 12 cycles from reset -> out runs 1..9, 0, 1, 2; wrap_evt high exactly once, in the cycle after 9->0.
REQ-031 Saturate down: MAX=255, mode=1, load_val=2, load, then ud=0, en=1 for 4 cycles -> out runs 2, 1, 0, 0, 0; sat_flag set from the edge of the first blocked count; clr_flag pulse with en=0 -> sat_flag=0.
REQ-032 Load clamp: MAX=9, load_val=200, load=1, en=1 -> out=9, wrap_evt=0; the next up edge in WRAP mode -> out=0.
REQ-033 Priority: reset=1, load=1, en=1 on the same edge -> out=0; then load=1 and en=1 with load_val=5 -> out=5, not 1.
REQ-034 Alternation: MAX=255, mode=0, en=1; ud toggles every 6 cycles from out=0, with reset pulses every 20 cycles -> out matches a reference model every cycle; wrap 0->255 on the first down edge at 0; tc matches REQ-021.
REQ-035 Set/clear collision: MAX=3, mode=1, out=3, ud=1, en=1, clr_flag=1 on the same edge -> sat_flag=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down modulo counter.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count logic: steps toward the bound, then either wraps
// or reports a blocked (saturating) attempt.
import counter_pkg::*;

module counter_next #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] out,
  input  logic             ud,
  input  logic             mode,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap,
  output logic             sat
);

  logic at_bound;

  always_comb begin
    nxt      = out;
    wrap     = 1'b0;
    sat      = 1'b0;
    at_bound = ud ? (out == MAX) : (out == '0);
    if (!at_bound) begin
      // Only reached below the bound, so the increment never overflows WIDTH.
      nxt = ud ? (out + WIDTH'(1)) : (out - WIDTH'(1));
    end else if (mode == MODE_WRAP) begin
      nxt  = ud ? '0 : MAX;
      wrap = 1'b1;
    end else begin
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/counter_ud_mod.sv
// Up/down counter with programmable bound, wrap or saturate behaviour,
// clamped load, wrap pulse and sticky saturation flag.
import counter_pkg::*;

module counter_ud_mod #(
  parameter int unsigned      WIDTH = 8,
  parameter longint unsigned  MAX   = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap_evt,
  output logic             sat_flag
);

  if (WIDTH < 2 || WIDTH > 32 || MAX == 0 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_param
    $error("counter_ud_mod: WIDTH must be 2..32 and MAX must be 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] out_reg;
  logic             wrap_reg;
  logic             sat_reg;
  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic             step_sat;
  logic [WIDTH-1:0] load_clamped;

  counter_next #(
    .WIDTH (WIDTH),
    .MAX   (MAX_V)
  ) u_next (
    .out  (out_reg),
    .ud   (ud),
    .mode (mode),
    .nxt  (step_next),
    .wrap (step_wrap),
    .sat  (step_sat)
  );

  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg  <= '0;
      wrap_reg <= 1'b0;
      sat_reg  <= 1'b0;
    end else begin
      if (load) begin
        out_reg <= load_clamped;
      end else if (en) begin
        out_reg <= step_next;
      end
      wrap_reg <= !load && en && step_wrap;
      // A blocked count on the same edge as a clear keeps the flag set.
      sat_reg  <= (sat_reg && !clr_flag) || (!load && en && step_sat);
    end
  end

  assign out      = out_reg;
  assign wrap_evt = wrap_reg;
  assign sat_flag = sat_reg;
  assign tc       = ud ? (out_reg == MAX_V) : (out_reg == '0);

endmodule
